// File: rtl/rnn_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rnn_layer_seq
//  Description : Binary recurrent layer with N_HID hidden neurons, full
//                hidden-to-hidden recurrence and one binary output neuron.
//                Weights are loadable at runtime. A single serial MAC
//                evaluates one time-step per OUT_REQ/OUT_ACK transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module rnn_layer_seq #(
    parameter  int N_IN  = 3,
    parameter  int N_HID = 4,
    parameter  int WW    = 4,
    localparam int c_aw  = $clog2(N_HID * (N_IN + N_HID + 1) + N_HID + 1)
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                OUT_REQ,
    output logic                OUT_ACK,
    output logic                OUT_DATA,
    output logic                IN_REQ,
    input  logic                IN_ACK,
    input  logic [N_IN-1:0]     IN_DATA,
    input  logic                CFG_WE,
    input  logic [c_aw-1:0]     CFG_ADDR,
    input  logic [WW-1:0]       CFG_WDATA,
    input  logic                STATE_CLR,
    output logic                CFG_BUSY
);

    // Terms per hidden neuron, total weights, accumulator and term-index widths
    localparam int c_nt   = N_IN + N_HID + 1;
    localparam int c_nw   = N_HID * c_nt + N_HID + 1;
    localparam int c_accw = WW + $clog2(c_nt + 1);
    localparam int c_tw   = $clog2(c_nt);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_fetch  = 3'd1;
    localparam logic [2:0] c_s_hid    = 3'd2;
    localparam logic [2:0] c_s_commit = 3'd3;
    localparam logic [2:0] c_s_outn   = 3'd4;
    localparam logic [2:0] c_s_ack    = 3'd5;

    logic [2:0]               r_state;
    logic signed [WW-1:0]     r_w [c_nw];
    logic [N_HID-1:0]         r_h_state;
    logic [N_HID-1:0]         r_h_next;
    logic [N_IN-1:0]          r_in;
    logic signed [c_accw-1:0] r_acc;
    logic [c_aw-1:0]          r_addr;
    logic [c_tw-1:0]          r_term;

    logic signed [WW-1:0]     w_w;
    logic signed [c_accw-1:0] w_ext;
    logic signed [c_accw-1:0] w_sum;
    logic [c_nt-1:0]          w_hid_src;
    logic [c_nt-1:0]          w_out_src;
    logic                     w_src;
    logic                     w_fire;
    logic [N_HID-1:0]         w_h_next_shift;

    // Term sources: hidden neurons see {bias, previous state, inputs};
    // the output neuron sees {bias, freshly committed state}, zero-padded.
    assign w_hid_src = {1'b1, r_h_state, r_in};
    assign w_out_src = {{(c_nt - N_HID - 1){1'b0}}, 1'b1, r_h_state};

    // Serial MAC datapath: selected weight, sign extension and threshold
    always_comb begin
        w_w    = r_w[r_addr];
        w_ext  = {{(c_accw - WW){w_w[WW-1]}}, w_w};
        w_src  = (r_state == c_s_hid) ? w_hid_src[r_term] : w_out_src[r_term];
        w_sum  = r_acc + (w_src ? w_ext : '0);
        w_fire = !w_sum[c_accw-1] && (w_sum != '0);
    end

    // Hidden results shift in from the top so neuron 0 ends up in bit 0
    generate
        if (N_HID > 1) begin : g_shift_multi
            assign w_h_next_shift = {w_fire, r_h_next[N_HID-1:1]};
        end else begin : g_shift_one
            assign w_h_next_shift = w_fire;
        end
    endgenerate

    assign CFG_BUSY = (r_state != c_s_idle);

    // Sequencer, weight store and recurrent state
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            r_state   <= c_s_idle;
            OUT_ACK   <= 1'b0;
            OUT_DATA  <= 1'b0;
            IN_REQ    <= 1'b0;
            r_h_state <= '0;
            r_h_next  <= '0;
            r_in      <= '0;
            r_acc     <= '0;
            r_addr    <= '0;
            r_term    <= '0;
            for (int i = 0; i < c_nw; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (CFG_WE && (CFG_ADDR < c_aw'(c_nw))) begin
                        r_w[CFG_ADDR] <= CFG_WDATA;
                    end
                    if (STATE_CLR) begin
                        r_h_state <= '0;
                    end
                    if (OUT_REQ) begin
                        r_state <= c_s_fetch;
                        IN_REQ  <= 1'b1;
                        r_acc   <= '0;
                        r_addr  <= '0;
                        r_term  <= '0;
                    end
                end
                c_s_fetch: begin
                    if (IN_ACK) begin
                        r_in    <= IN_DATA;
                        IN_REQ  <= 1'b0;
                        r_state <= c_s_hid;
                    end
                end
                c_s_hid: begin
                    r_addr <= r_addr + c_aw'(1);
                    if (r_term == c_tw'(c_nt - 1)) begin
                        r_h_next <= w_h_next_shift;
                        r_acc    <= '0;
                        r_term   <= '0;
                        if (r_addr == c_aw'(N_HID * c_nt - 1)) begin
                            r_state <= c_s_commit;
                        end
                    end else begin
                        r_acc  <= w_sum;
                        r_term <= r_term + c_tw'(1);
                    end
                end
                c_s_commit: begin
                    r_h_state <= r_h_next;
                    r_acc     <= '0;
                    r_term    <= '0;
                    r_state   <= c_s_outn;
                end
                c_s_outn: begin
                    r_addr <= r_addr + c_aw'(1);
                    if (r_term == c_tw'(N_HID)) begin
                        OUT_DATA <= w_fire;
                        OUT_ACK  <= 1'b1;
                        r_acc    <= '0;
                        r_state  <= c_s_ack;
                    end else begin
                        r_acc  <= w_sum;
                        r_term <= r_term + c_tw'(1);
                    end
                end
                c_s_ack: begin
                    if (!OUT_REQ) begin
                        OUT_ACK  <= 1'b0;
                        OUT_DATA <= 1'b0;
                        r_state  <= c_s_idle;
                    end
                end
                default: begin
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rnn_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rnn_layer_seq
//  Description : Self-checking bench for rnn_layer_seq with a behavioural
//                step model (weighted sums over arrays) and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rnn_layer_seq;

    localparam int c_lat = 38;

    logic       CLK = 1'b0;
    logic       RSTB = 1'b0;
    logic       OUT_REQ = 1'b0;
    logic       OUT_ACK;
    logic       OUT_DATA;
    logic       IN_REQ;
    logic       IN_ACK = 1'b0;
    logic [2:0] IN_DATA = '0;
    logic       CFG_WE = 1'b0;
    logic [5:0] CFG_ADDR = '0;
    logic [3:0] CFG_WDATA = '0;
    logic       STATE_CLR = 1'b0;
    logic       CFG_BUSY;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: signed weights and recurrent state
    int       mw [37];
    bit [3:0] mh;

    rnn_layer_seq dut (
        .CLK(CLK), .RSTB(RSTB), .OUT_REQ(OUT_REQ), .OUT_ACK(OUT_ACK),
        .OUT_DATA(OUT_DATA), .IN_REQ(IN_REQ), .IN_ACK(IN_ACK), .IN_DATA(IN_DATA),
        .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_WDATA(CFG_WDATA),
        .STATE_CLR(STATE_CLR), .CFG_BUSY(CFG_BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 37; i++) mw[i] = 0;
        mh = '0;
    endtask

    // One time-step: hidden sums from the previous state, then output from the new state
    task automatic model_step(input bit [2:0] x, output bit y);
        bit [3:0] hn;
        int s;
        for (int h = 0; h < 4; h++) begin
            s = mw[h*8 + 7];
            for (int j = 0; j < 3; j++) if (x[j]) s += mw[h*8 + j];
            for (int k = 0; k < 4; k++) if (mh[k]) s += mw[h*8 + 3 + k];
            hn[h] = (s > 0);
        end
        mh = hn;
        s = mw[36];
        for (int k = 0; k < 4; k++) if (mh[k]) s += mw[32 + k];
        y = (s > 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTB = 1'b0; OUT_REQ = 1'b0; IN_ACK = 1'b0; CFG_WE = 1'b0; STATE_CLR = 1'b0;
        repeat (2) @(negedge CLK);
        RSTB = 1'b1;
        model_reset();
    endtask

    task automatic write_weight(input int addr, input int val);
        logic [31:0] v;
        v = val;
        @(negedge CLK);
        CFG_WE = 1'b1; CFG_ADDR = addr[5:0]; CFG_WDATA = v[3:0];
        @(negedge CLK);
        CFG_WE = 1'b0;
        if (addr < 37) mw[addr] = (val > 7) ? val - 16 : val;
    endtask

    task automatic state_clear();
        @(negedge CLK);
        STATE_CLR = 1'b1;
        @(negedge CLK);
        STATE_CLR = 1'b0;
        mh = '0;
    endtask

    // Full handshake. d = idle FETCH cycles before IN_ACK; hold < 0 drops OUT_REQ
    // during compute; midwr issues a CFG write while the layer is busy.
    task automatic run_step(input bit [2:0] x, input int d, input int hold, input bit clr,
                            input bit midwr, input int mwa, input int mwd, output bit got);
        bit exp_y;
        int cnt;
        logic [31:0] v;
        v = mwd;
        if (clr) mh = '0;
        model_step(x, exp_y);
        @(negedge CLK);
        OUT_REQ = 1'b1; STATE_CLR = clr;
        @(negedge CLK);
        STATE_CLR = 1'b0;
        vectors++;
        if ({IN_REQ, CFG_BUSY} !== 2'b11) begin
            miscompares++;
            $display("FAIL fetch_req: IN_REQ,CFG_BUSY got %b need 11", {IN_REQ, CFG_BUSY});
        end
        repeat (d) @(negedge CLK);
        IN_DATA = x; IN_ACK = 1'b1;
        @(negedge CLK);
        IN_ACK = 1'b0;
        vectors++;
        if (IN_REQ !== 1'b0) begin
            miscompares++;
            $display("FAIL in_req_drop: IN_REQ got %b need 0", IN_REQ);
        end
        cnt = 0;
        while (OUT_ACK !== 1'b1 && cnt < 100) begin
            if (hold < 0 && cnt == 2) OUT_REQ = 1'b0;
            if (midwr && cnt == 3) begin
                CFG_WE = 1'b1; CFG_ADDR = mwa[5:0]; CFG_WDATA = v[3:0];
            end
            if (cnt == 4) CFG_WE = 1'b0;
            @(posedge CLK);
            cnt++;
            @(negedge CLK);
        end
        CFG_WE = 1'b0;
        vectors++;
        if (cnt !== c_lat) begin
            miscompares++;
            $display("FAIL latency: OUT_ACK after %0d edges need %0d", cnt, c_lat);
        end
        got = OUT_DATA;
        vectors++;
        if (OUT_DATA !== exp_y) begin
            miscompares++;
            $display("FAIL out_data: x=%b got %b need %b", x, OUT_DATA, exp_y);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            vectors++;
            if ({OUT_ACK, OUT_DATA} !== {1'b1, exp_y}) begin
                miscompares++;
                $display("FAIL ack_hold: got %b need %b", {OUT_ACK, OUT_DATA}, {1'b1, exp_y});
            end
        end
        OUT_REQ = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({OUT_ACK, OUT_DATA, CFG_BUSY} !== 3'b000) begin
            miscompares++;
            $display("FAIL ack_release: ACK,DATA,BUSY got %b need 000",
                     {OUT_ACK, OUT_DATA, CFG_BUSY});
        end
    endtask

    task automatic test_reset();
        bit y;
        @(negedge CLK);
        RSTB = 1'b0;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({OUT_ACK, OUT_DATA, IN_REQ, CFG_BUSY} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b need 0000", {OUT_ACK, OUT_DATA, IN_REQ, CFG_BUSY});
        end
        RSTB = 1'b1;
        model_reset();
        run_step(3'b101, 0, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_zero_weights: got %b need 0", y);
        end
    endtask

    task automatic test_bias_only();
        bit y;
        do_reset();
        write_weight(36, 1);
        run_step(3'b000, 1, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b1) begin
            miscompares++;
            $display("FAIL bias_only: got %b need 1", y);
        end
    endtask

    task automatic test_recurrence();
        bit y;
        do_reset();
        write_weight(0, 3); write_weight(3, 2); write_weight(7, 15);
        write_weight(32, 1); write_weight(36, 0);
        run_step(3'b001, 0, 1, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b1) begin miscompares++; $display("FAIL rec_first: got %b need 1", y); end
        run_step(3'b000, 2, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b1) begin miscompares++; $display("FAIL rec_hold: got %b need 1", y); end
        state_clear();
        run_step(3'b000, 0, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b0) begin miscompares++; $display("FAIL rec_clear: got %b need 0", y); end
        run_step(3'b001, 0, 0, 1'b0, 1'b0, 0, 0, y);
        run_step(3'b000, 0, 0, 1'b1, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b0) begin miscompares++; $display("FAIL clr_with_req: got %b need 0", y); end
    endtask

    task automatic test_threshold();
        bit y;
        do_reset();
        run_step(3'b111, 0, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b0) begin miscompares++; $display("FAIL thr_zero: got %b need 0", y); end
        write_weight(36, 8);
        run_step(3'b010, 0, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b0) begin miscompares++; $display("FAIL thr_neg8: got %b need 0", y); end
        write_weight(36, 7);
        for (int h = 0; h < 4; h++) begin
            write_weight(h*8 + 7, 1);
            write_weight(32 + h, 8);
        end
        run_step(3'b000, 0, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b0) begin miscompares++; $display("FAIL thr_sum_neg: got %b need 0", y); end
    endtask

    task automatic test_ignored_writes();
        bit y;
        do_reset();
        write_weight(36, 1);
        run_step(3'b000, 0, -1, 1'b0, 1'b1, 36, 8, y);
        vectors++;
        if (y !== 1'b1) begin miscompares++; $display("FAIL busy_write_step: got %b need 1", y); end
        write_weight(37, 8);
        run_step(3'b000, 0, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b1) begin miscompares++; $display("FAIL ignored_writes: got %b need 1", y); end
    endtask

    task automatic test_reset_mid_compute();
        bit y;
        do_reset();
        write_weight(36, 1); write_weight(7, 1);
        run_step(3'b000, 0, 0, 1'b0, 1'b0, 0, 0, y);
        @(negedge CLK);
        OUT_REQ = 1'b1;
        @(negedge CLK);
        IN_DATA = 3'b111; IN_ACK = 1'b1;
        @(negedge CLK);
        IN_ACK = 1'b0;
        repeat (10) @(negedge CLK);
        RSTB = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({IN_REQ, OUT_ACK, CFG_BUSY} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_hid: IN_REQ,ACK,BUSY got %b need 000", {IN_REQ, OUT_ACK, CFG_BUSY});
        end
        RSTB = 1'b1; OUT_REQ = 1'b0;
        model_reset();
        run_step(3'b000, 0, 0, 1'b0, 1'b0, 0, 0, y);
        vectors++;
        if (y !== 1'b0) begin miscompares++; $display("FAIL after_mid_reset: got %b need 0", y); end
    endtask

    task automatic test_random();
        bit y;
        int hold;
        do_reset();
        for (int it = 0; it < 25; it++) begin
            for (int n = 0; n < int'($urandom_range(1, 4)); n++)
                write_weight($urandom_range(0, 39), $urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) state_clear();
            hold = int'($urandom_range(0, 3)) - 1;
            run_step(3'($urandom_range(0, 7)), $urandom_range(0, 3), hold,
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 39), $urandom_range(0, 15), y);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bias_only();
        test_recurrence();
        test_threshold();
        test_ignored_writes();
        test_reset_mid_compute();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
